// File: rtl/param_updown_counter.sv
// rtl/param_updown_counter.sv - up/down counter with prescaler, load, programmable terminal value, wrap/saturate
// Boundary steps raise a one-cycle tc strobe and set the sticky ovf flag.
module param_updown_counter #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
  parameter int unsigned      PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  input  logic             sat,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned     PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]   PRE_LAST = PW'(PRESCALE - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             tick;

  assign tick = en && (pre_q == PRE_LAST);

  // tc defaults low so it only survives for the cycle after a boundary step.
  always_comb begin
    count_d = count_q;
    pre_d   = pre_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q;
    if (clr) begin
      count_d = '0;
      pre_d   = '0;
      ovf_d   = 1'b0;
    end else if (load) begin
      count_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
      pre_d   = '0;
    end else if (en) begin
      pre_d = tick ? '0 : pre_q + 1'b1;
      if (tick) begin
        if (dir) begin
          if (count_q == MAX_VAL) begin
            tc_d    = 1'b1;
            ovf_d   = 1'b1;
            count_d = sat ? MAX_VAL : '0;
          end else begin
            count_d = count_q + 1'b1;
          end
        end else begin
          if (count_q == '0) begin
            tc_d    = 1'b1;
            ovf_d   = 1'b1;
            count_d = sat ? '0 : MAX_VAL;
          end else begin
            count_d = count_q - 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      pre_q   <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      pre_q   <= pre_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;
  assign zero  = (count_q == '0);

endmodule
